// File: rtl/pwm_multich_peripheral.sv
// Multi-channel PWM peripheral with register-write interface.
//
// A shared prescaler and 8-bit period counter drive NUM_CH compare channels.
// Period length (TOP) and per-channel duty (DUTY) are double-buffered:
// writes land in shadow registers and reach the active copies only at a
// load event (counter wrap, the cycle after a SYNC write, or any cycle
// while stopped), so a period is never torn by a mid-period update.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr_en         one-cycle register write strobe
//   wr_addr[6:0]  register address
//   wr_data[7:0]  register write data
//   pwm_out       registered channel outputs, one clk behind the counter
//   period_start  one-clk pulse following each counter wrap
//
// Address map:
//   0x00+k  EN_OUT byte k     0x08+k  EN_PWM byte k    (k < NUM_CH/8)
//   0x10    PRESC             0x11    TOP (shadow)
//   0x12    CTRL: bit0 RUN, bit1 SYNC (pulse, not stored)
//   0x20+ch DUTY[ch] (shadow)
module pwm_multich_peripheral #(
  parameter int NUM_CH  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam int         NUM_BYTES  = NUM_CH / 8;
  localparam logic [6:0] ADDR_PRESC = 7'h10;
  localparam logic [6:0] ADDR_TOP   = 7'h11;
  localparam logic [6:0] ADDR_CTRL  = 7'h12;

  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] psc_cnt;
  logic [7:0]         top_sh;
  logic [7:0]         top_act;
  logic [7:0]         cnt;
  logic [7:0]         duty_sh  [NUM_CH];
  logic [7:0]         duty_act [NUM_CH];
  logic               run;
  logic               sync_q;
  logic               ctrl_wr;
  logic               tick;
  logic               wrap;
  logic               load;
  logic [NUM_CH-1:0]  pwm_level;
  logic [NUM_CH-1:0]  pwm_next;

  assign ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
  assign tick    = (psc_cnt >= presc);
  // >= rather than == so a counter stranded above a newly shortened TOP
  // wraps on its next tick instead of running on to 0xFF.
  assign wrap    = run && !sync_q && tick && (cnt >= top_act);
  assign load    = wrap || sync_q || !run;

  // Directly-effective configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= '0;
      en_pwm <= '0;
      presc  <= '0;
      run    <= 1'b1;
      sync_q <= 1'b0;
    end else begin
      sync_q <= ctrl_wr && wr_data[1];
      if (ctrl_wr)
        run <= wr_data[0];
      if (wr_en && (wr_addr == ADDR_PRESC))
        presc <= wr_data[PRESC_W-1:0];
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (wr_en && (wr_addr == 7'(k)))
          en_out[8*k +: 8] <= wr_data;
        if (wr_en && (wr_addr == 7'(8 + k)))
          en_pwm[8*k +: 8] <= wr_data;
      end
    end
  end

  // Shadow/active pairs. On a load coinciding with a shadow write the
  // active copy takes the old shadow value; the new one waits for the
  // next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_sh  <= 8'hFF;
      top_act <= 8'hFF;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        duty_sh[ch]  <= 8'h00;
        duty_act[ch] <= 8'h00;
      end
    end else begin
      if (wr_en && (wr_addr == ADDR_TOP))
        top_sh <= wr_data;
      if (load)
        top_act <= top_sh;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_en && (wr_addr == 7'(32 + ch)))
          duty_sh[ch] <= wr_data;
        if (load)
          duty_act[ch] <= duty_sh[ch];
      end
    end
  end

  // Prescaler and period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt      <= '0;
      cnt          <= 8'h00;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (!run || sync_q) begin
        psc_cnt <= '0;
        cnt     <= 8'h00;
      end else if (tick) begin
        psc_cnt <= '0;
        cnt     <= (cnt >= top_act) ? 8'h00 : cnt + 8'd1;
      end else begin
        psc_cnt <= psc_cnt + 1'b1;
      end
    end
  end

  // Compare level: DUTY=0xFF or DUTY beyond TOP means always on.
  always_comb begin
    pwm_level = '0;
    pwm_next  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pwm_level[ch] = (cnt < duty_act[ch]) || (duty_act[ch] == 8'hFF) ||
                      (duty_act[ch] > top_act);
      if (!en_out[ch])
        pwm_next[ch] = 1'b0;
      else if (!en_pwm[ch])
        pwm_next[ch] = 1'b1;
      else if (!run)
        pwm_next[ch] = 1'b0;
      else
        pwm_next[ch] = pwm_level[ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_out <= '0;
    else
      pwm_out <= pwm_next;
  end

endmodule

// File: doc/pwm_multich_peripheral.md
PWM_MULTICH_PERIPHERAL -- requirements
Module: pwm_multich_peripheral

Interface
REQ-001 Parameter NUM_CH, default 16, SHALL set the number of PWM channels; legal values are 8, 16, 24 or 32.
REQ-002 Parameter PRESC_W, default 8, SHALL set the prescaler register width in bits (1..8).
REQ-003 clk  input  1  SHALL be the single clock; all state is rising-edge clocked.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 wr_en  input  1  SHALL be a single-cycle register write strobe from the SPI peripheral.
REQ-006 wr_addr  input  7  SHALL be the register address.
REQ-007 wr_data  input  8  SHALL be the register write data.
REQ-008 pwm_out  output  NUM_CH  SHALL carry the registered channel outputs.
REQ-009 period_start  output  1  SHALL pulse high for one clk at each counter wrap.

Function
REQ-010 The address map SHALL be as follows: 0x00+k EN_OUT byte k and 0x08+k EN_PWM byte k, for k=0..NUM_CH/8-1; 0x10 PRESC; 0x11 TOP; 0x12 CTRL (bit0 RUN, bit1 SYNC); 0x20+ch DUTY[ch].
REQ-011 A write to an unmapped address, or to an address beyond NUM_CH, SHALL be ignored.
REQ-012 EN_OUT, EN_PWM, PRESC and CTRL.RUN writes SHALL take effect on the clk after wr_en.
REQ-013 TOP and DUTY writes SHALL go to shadow registers and be copied to the active registers only at a load event.
REQ-014 Load events SHALL be: counter wrap; the cycle after a CTRL write with SYNC=1; and every cycle while RUN=0.
REQ-015 The prescaler counter SHALL produce a tick when it reaches PRESC or more, then clear; otherwise it increments, so a tick occurs every PRESC+1 clks.
REQ-016 The 8-bit period counter cnt SHALL increment on each tick.
REQ-017 When cnt equals active TOP and a tick occurs, cnt SHALL wrap to 0 and period_start SHALL assert on the following clk.
REQ-018 If cnt exceeds active TOP after a TOP change, cnt SHALL wrap to 0 on the next tick.
REQ-019 A CTRL write with SYNC=1 SHALL clear cnt and the prescaler counter and perform a load; SYNC is not stored and reads as a pulse only.
REQ-020 While RUN=0, cnt and the prescaler counter SHALL be held at 0 and period_start SHALL be held at 0.
REQ-021 The per-channel PWM level SHALL be 1 when (cnt < active DUTY) or (active DUTY = 0xFF) or (active DUTY > active TOP), and 0 otherwise; DUTY=0 SHALL give a constant 0.
REQ-022 pwm_out[ch] SHALL be registered with the following priority: EN_OUT[ch]=0 gives 0; else EN_PWM[ch]=0 gives 1; else RUN=0 gives 0; else the PWM level from REQ-021.
REQ-023 pwm_out SHALL lag cnt by exactly one clk.
REQ-024 Simultaneous shadow write and load event: the active register SHALL take the pre-write shadow value; the new value applies at the next load event.
REQ-025 Simultaneous writes are not possible (single port); back-to-back wr_en on consecutive clks SHALL all be accepted.

Reset
REQ-026 On rst_n low, asynchronously: EN_OUT=0, EN_PWM=0, PRESC=0, shadow and active TOP=0xFF, all DUTY=0, RUN=1, cnt=0, prescaler counter=0, pwm_out=0, period_start=0.
REQ-027 Reset asserted mid-period SHALL abort the period immediately; after release, counting SHALL restart from cnt=0 on the first clk.

Verification
REQ-028 Reset defaults, then write EN_OUT 0x00=0xFF and leave EN_PWM=0 -> pwm_out[7:0]=0xFF two clks after wr_en; upper channels remain 0.
REQ-029 Set EN_OUT/EN_PWM bit0, DUTY[0]=0x40, PRESC=0, TOP=0xFF -> ch0 high for 64 of every 256 clks; period_start once per 256 clks.
REQ-030 PRESC=3, TOP=9, DUTY[1]=5 -> period of 40 clks; ch1 high for 20 clks; DUTY[1]=0xFF or 12 -> constant high; DUTY[1]=0 -> constant low.
REQ-031 Write DUTY[2] mid-period, and separately on the exact wrap cycle -> mid-period change visible only from the next period_start; the wrap-cycle write is delayed one further period.
REQ-032 CTRL=0x00 -> PWM-mode channels low and cnt held at 0; then CTRL=0x03 -> cnt restarts at 0 and new shadows are active immediately.
REQ-033 Assert rst_n low at cnt=0x80 with traffic active -> all outputs 0 within the same cycle; after release, register defaults hold and cnt starts at 0.
